// File: rtl/des_perm_unit_if.sv
// des_perm_unit_if: input/output block handshakes of the DES permutation unit.
interface des_perm_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode;
    logic [63:0] out_data;
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );
endinterface

// File: rtl/des_perm_unit.sv
// des_perm_unit: DES IP/FP bit permutation into an output FIFO.
// DES_PERM_SELFCHECK_EN keeps the original block per entry and checks the inverse on pop.
module des_perm_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    des_perm_unit_if.slave         bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   chk_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef DES_PERM_SELFCHECK_EN
    localparam int EW = 129;
`else
    localparam int EW = 65;
`endif
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_cnt;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Closed-form FIPS tables: position p = 8*row + col, source DES bit t.
    function automatic logic [63:0] perm(input logic [63:0] d, input logic fp);
        logic [63:0] q;
        int r, c, t;
        q = '0;
        for (int p = 0; p < 64; p++) begin
            r = p / 8;
            c = p % 8;
            t = fp ? ((c % 2 == 1) ? 4 : 40) + 4 * c - r : ((r < 4) ? 58 : 49) + 2 * r - 8 * c;
            q[6'(63 - p)] = d[6'(64 - t)];
        end
        return q;
    endfunction

    assign w_full        = r_level == LW'(DEPTH);
    assign bus.in_ready  = !w_full && !flush && !rst;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;
    assign w_head        = r_mem[r_rd];
    assign bus.out_valid = r_level != '0;
    assign bus.out_mode  = w_head[64];
    assign bus.out_data  = w_head[63:0];
    assign level         = r_level;
    assign blk_count     = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_entry;
                r_cnt       <= r_cnt + 1'b1;
            end
            if (flush) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_level <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop) r_rd <= r_rd + 1'b1;
                r_level <= r_level + LW'(w_push) - LW'(w_pop);
            end
        end
    end

`ifdef DES_PERM_SELFCHECK_EN
    logic r_chk_err;
    logic w_mismatch;
    assign w_entry    = {bus.in_data, bus.in_mode, perm(bus.in_data, bus.in_mode)};
    assign w_mismatch = w_pop && !flush && perm(bus.out_data, !bus.out_mode) != w_head[128:65];
    assign chk_err    = r_chk_err;
    always_ff @(posedge clk) begin
        if (rst) r_chk_err <= 1'b0;
        else if (w_mismatch) r_chk_err <= 1'b1;
    end
`else
    assign w_entry = {bus.in_mode, perm(bus.in_data, bus.in_mode)};
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_des_perm_unit.sv
// tb_des_perm_unit: random and directed stimulus against a table-driven queue model.
module tb_des_perm_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  level;
    logic [3:0]  blk_count;
    logic        chk_err;
    int          total = 0;
    int          bad = 0;
    bit          chk_on = 1'b0;
    logic [64:0] mq[$];
    int          mcnt = 0;

    int ip_t[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                     62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                     38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

    des_perm_unit_if bus();

    des_perm_unit #(.DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .level(level), .blk_count(blk_count), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mperm(input logic [63:0] x, input logic fp);
        logic [63:0] r;
        for (int k = 1; k <= 64; k++) r[6'(64 - k)] = x[6'(64 - (fp ? fp_t[k-1] : ip_t[k-1]))];
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // One block in with the consumer always ready; returns the head seen after the accept edge.
    task automatic xfer(input logic m, input logic [63:0] d, output logic [63:0] res);
        bus.in_valid = 1'b1;
        bus.in_mode = m;
        bus.in_data = d;
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        res = bus.out_data;
    endtask

    always @(posedge clk) begin
        bit push, pop;
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            pop = mq.size() != 0 && bus.out_ready;
            push = bus.in_valid && mq.size() < 4 && !flush;
            if (flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back({bus.in_mode, mperm(bus.in_data, bus.in_mode)});
            end
            if (push) mcnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            check("level", 64'(level), 64'(mq.size()));
            check("blk_count", 64'(blk_count), 64'(mcnt % 16));
            check("chk_err", 64'(chk_err), 64'd0);
            check("in_ready", 64'(bus.in_ready), 64'(mq.size() < 4 && !flush && !rst));
            if (mq.size() != 0) begin
                check("out_mode", 64'(bus.out_mode), 64'(mq[0][64]));
                check("out_data", bus.out_data, mq[0][63:0]);
            end
        end
    end

    initial begin
        logic [63:0] r, r2, acc, x;
        logic [63:0] d[5];
        logic [3:0]  bc;
        bus.in_valid = 1'b0;
        bus.in_mode = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        chk_on = 1'b1;
        check("rst level", 64'(level), 64'd0);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out_mode", 64'(bus.out_mode), 64'd0);
        check("rst out_data", bus.out_data, 64'd0);
        check("rst blk_count", 64'(blk_count), 64'd0);
        check("rst chk_err", 64'(chk_err), 64'd0);
        check("rst in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready after rst", 64'(bus.in_ready), 64'd1);
        check("model ip kat", mperm(64'h0123456789ABCDEF, 1'b0), 64'hCC00CCFFF0AAF0AA);
        check("model fp kat", mperm(64'hCC00CCFFF0AAF0AA, 1'b1), 64'h0123456789ABCDEF);
        xfer(1'b0, 64'h0123456789ABCDEF, r);
        check("ip kat", r, 64'hCC00CCFFF0AAF0AA);
        check("ip kat mode", 64'(bus.out_mode), 64'd0);
        check("ip kat valid", 64'(bus.out_valid), 64'd1);
        xfer(1'b0, 64'h0000000000000040, r);
        check("ip bit58", r, 64'h8000000000000000);
        xfer(1'b1, 64'h0000000001000000, r);
        check("fp bit40", r, 64'h8000000000000000);
        check("fp bit40 mode", 64'(bus.out_mode), 64'd1);
        xfer(1'b1, 64'hCC00CCFFF0AAF0AA, r);
        check("fp kat", r, 64'h0123456789ABCDEF);
        for (int m = 0; m < 2; m++) begin
            acc = '0;
            for (int i = 0; i < 64; i++) begin
                xfer(m[0], 64'd1 << i, r);
                check("onehot popcount", 64'($countones(r)), 64'd1);
                check("onehot distinct", r & acc, 64'd0);
                acc = acc | r;
            end
            check("onehot cover", acc, '1);
        end
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom(), $urandom()};
            xfer(1'b0, x, r);
            xfer(1'b1, r, r2);
            check("round trip", r2, x);
        end
        cyc();
        check("drained", 64'(level), 64'd0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) d[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_mode = i[0];
            bus.in_data = d[i];
            check("bp in_ready", 64'(bus.in_ready), 64'd1);
            cyc();
        end
        check("bp full level", 64'(level), 64'd4);
        check("bp full in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_mode = 1'b0;
        bus.in_data = d[4];
        cyc();
        check("bp held level", 64'(level), 64'd4);
        check("bp head data", bus.out_data, mperm(d[0], 1'b0));
        check("bp head mode", 64'(bus.out_mode), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp full pop in_ready", 64'(bus.in_ready), 64'd0);
        cyc();
        check("bp after pop level", 64'(level), 64'd3);
        check("bp second head", bus.out_data, mperm(d[1], 1'b1));
        cyc();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("bp drained", 64'(level), 64'd0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = {$urandom(), $urandom()};
            cyc();
        end
        check("flush pre level", 64'(level), 64'd3);
        bc = blk_count;
        flush = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush level", 64'(level), 64'd0);
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        check("flush blk_count", 64'(blk_count), 64'(bc));
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check("mid rst level", 64'(level), 64'd0);
        check("mid rst out_valid", 64'(bus.out_valid), 64'd0);
        check("mid rst out_data", bus.out_data, 64'd0);
        check("mid rst out_mode", 64'(bus.out_mode), 64'd0);
        check("mid rst blk_count", 64'(blk_count), 64'd0);
        check("mid rst in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("after mid rst in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 17; i++) xfer(i[0], {$urandom(), $urandom()}, r);
        check("count wrap", 64'(blk_count), 64'd1);
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_mode = 1'($urandom_range(0, 1));
            bus.in_data = {$urandom(), $urandom()};
            bus.out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 49) == 0;
            rst = $urandom_range(0, 199) == 0;
            cyc();
        end
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
